data_mem_ctrl: RTL

- Parametrised, handshaked successor to the pipeline's byte-addressed data RAM.
- Serves the MEM stage: byte/halfword/word/doubleword loads and stores; optional sign extension; alignment and range checking.
- Doubleword reads return as two response beats under a small FSM with response backpressure.
- Replaces the event-triggered Enable/ReadWrite RAM with a clocked valid/ready interface.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/data_mem_ctrl_if.sv | 30 +++
 rtl/dmem_byte_array.sv | 33 +++
 rtl/data_mem_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory controller.
package dmem_pkg;

    localparam logic [1:0] MODE_BYTE  = 2'b00;
    localparam logic [1:0] MODE_HALF  = 2'b01;
    localparam logic [1:0] MODE_WORD  = 2'b10;
    localparam logic [1:0] MODE_DWORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RSP  = 2'd1,
        RSP2 = 2'd2
    } state_e;

    function automatic logic [3:0] size_of_mode(input logic [1:0] mode);
        return 4'd1 << mode;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the MEM stage and the data memory controller.
interface data_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [1:0]        req_mode;
    logic              req_sign;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       req_wdata_hi;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_last;
    logic              rsp_err;

    modport master (
        output req_valid, req_rw, req_mode, req_sign, req_addr, req_wdata, req_wdata_hi,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );

    modport slave (
        input  req_valid, req_rw, req_mode, req_sign, req_addr, req_wdata, req_wdata_hi,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );
endinterface

// File: rtl/dmem_byte_array.sv
// Byte-addressed storage with an 8-byte combinational read window and per-lane writes.
module dmem_byte_array #(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] base,
    output logic [63:0]              rdata,
    input  logic [7:0]               we,
    input  logic [63:0]              wdata
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] lane_addr [8];

    // Lane i holds the byte at base+i; the window wraps, callers only use in-range windows.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            lane_addr[i]     = base + AW'(i);
            rdata[8*i +: 8]  = mem[lane_addr[i]];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (we[i]) begin
                mem[lane_addr[i]] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked byte/half/word/dword data memory controller with registered responses.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input logic            clk,
    input logic            clr,
    data_mem_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    state_e      state_q, state_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_last_q, rsp_last_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] hold_q, hold_d;

    logic              accept;
    logic [3:0]        size;
    logic [3:0]        size_m1;
    logic [ADDR_W:0]   end_addr;
    logic              misaligned;
    logic              out_of_range;
    logic              req_err;
    logic [63:0]       rd_win;
    logic [63:0]       wr_lanes;
    logic [7:0]        we;
    logic [31:0]       rd_lo;
    logic [31:0]       rd_hi;
    logic [15:0]       rd_half;
    logic [31:0]       rd_val;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign bus.req_ready = (state_q == IDLE) && !clr;
    assign accept        = bus.req_valid && bus.req_ready;

    dmem_byte_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .base  (bus.req_addr[AW-1:0]),
        .rdata (rd_win),
        .we    (we),
        .wdata (wr_lanes)
    );

    // Range check one bit wider than the address so addr + size - 1 cannot wrap.
    always_comb begin
        size         = size_of_mode(bus.req_mode);
        size_m1      = size - 4'd1;
        misaligned   = |(bus.req_addr[2:0] & size_m1[2:0]);
        end_addr     = {1'b0, bus.req_addr} + (ADDR_W+1)'(size_m1);
        out_of_range = end_addr >= (ADDR_W+1)'(DEPTH);
        req_err      = misaligned || out_of_range;
    end

    // Lane 0 is the byte at addr; big-endian puts the value's MSB there.
    always_comb begin
        wr_lanes = '0;
        case (bus.req_mode)
            MODE_BYTE: wr_lanes = {56'd0, bus.req_wdata[7:0]};
            MODE_HALF: wr_lanes = {48'd0, BIG_ENDIAN ? {bus.req_wdata[7:0], bus.req_wdata[15:8]}
                                                     : bus.req_wdata[15:0]};
            MODE_WORD: wr_lanes = {32'd0, BIG_ENDIAN ? bswap32(bus.req_wdata) : bus.req_wdata};
            MODE_DWORD: wr_lanes = BIG_ENDIAN ? {bswap32(bus.req_wdata_hi), bswap32(bus.req_wdata)}
                                              : {bus.req_wdata_hi, bus.req_wdata};
            default: wr_lanes = '0;
        endcase
        we = '0;
        if (accept && bus.req_rw && !req_err) begin
            we = 8'((16'd1 << size) - 16'd1);
        end
    end

    always_comb begin
        rd_lo   = BIG_ENDIAN ? bswap32(rd_win[31:0]) : rd_win[31:0];
        rd_hi   = BIG_ENDIAN ? bswap32(rd_win[63:32]) : rd_win[63:32];
        rd_half = BIG_ENDIAN ? {rd_win[7:0], rd_win[15:8]} : rd_win[15:0];
        rd_val  = rd_lo;
        case (bus.req_mode)
            MODE_BYTE: rd_val = bus.req_sign ? {{24{rd_win[7]}}, rd_win[7:0]}
                                             : {24'd0, rd_win[7:0]};
            MODE_HALF: rd_val = bus.req_sign ? {{16{rd_half[15]}}, rd_half}
                                             : {16'd0, rd_half};
            MODE_WORD, MODE_DWORD: rd_val = rd_lo;
            default: rd_val = rd_lo;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        hold_d      = hold_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 32'd0;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = req_err;
                    if (!req_err && !bus.req_rw) begin
                        rsp_data_d = rd_val;
                        if (bus.req_mode == MODE_DWORD) begin
                            rsp_last_d = 1'b0;
                            hold_d     = rd_hi;
                        end
                    end
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    if (rsp_last_q) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b0;
                    end else begin
                        state_d    = RSP2;
                        rsp_data_d = hold_q;
                        rsp_last_d = 1'b1;
                    end
                end
            end
            RSP2: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            hold_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            hold_q      <= hold_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
